alu_arith_seq: RTL and testbench
================================

// Module: alu_arith_seq
// PURPOSE
// Parametrised, multi-cycle successor to the combinational arithmetic ALU.
// Adds to add/sub/mov an iterative unsigned multiply, divide and remainder.
// All results and flags are registered, with a start/ready/done handshake.
// Sits between the datapath register file and writeback. The control FSM
// issues one op at a time.
// PARAMETERS
// N   4   operand/result width in bits (N >= 2)
// PORTS
// clk_i        in   1  clock, rising edge
// rst_i        in   1  reset, asynchronous, active-high
// start_i      in   1  request; accepted only when start_i && ready_o
// opcode_i     in   3  operation select, sampled on accept
// a_i          in   N  operand A, sampled on accept
// b_i          in   N  operand B, sampled on accept
// ready_o      out  1  unit idle, can accept
// done_o       out  1  one-cycle pulse: result_o/flags valid from this cycle on
// result_o     out  N  result, held until the next done_o
// cout_o       out  1  carry/borrow/product-high flag, held with result
// overflow_o   out  1  signed overflow / divide-by-zero flag, held
// zero_o       out  1  result_o == 0, held
// negative_o   out  1  result_o[N-1], held
// BEHAVIOUR
// Reset: state IDLE; ready_o=1; done_o=0; result_o=0; all flags 0; internal regs 0.
// FSM: IDLE -> (accept, 1-cycle op) -> DONE -> IDLE.
//      IDLE -> (accept, mul/div/rem) -> ITER -> (counter==N-1) -> DONE -> IDLE.
// ready_o=1 only in IDLE. start_i in ITER or DONE is ignored and never queued.
// done_o=1 only in DONE, which lasts exactly 1 cycle.
// Max throughput: 1 op per 2 cycles (1-cycle ops) or per N+2 cycles (iterative ops).
// Latency, accept edge = cycle 0:
//   - 1-cycle ops: done_o in cycle 1.
//   - iterative ops: done_o in cycle N+1.
// Operand/opcode changes after accept have no effect.
// Opcodes (width rule: internal N+1-bit sums, results truncated to N):
//   000 ADD : r=a+b; cout=carry out bit N; V=~(a[N-1]^b[N-1])&(r[N-1]^a[N-1])
//   001 SUB : r=a-b; cout=borrow (bit N of N+1-bit a-b); V=(a[N-1]^b[N-1])&(r[N-1]^a[N-1])
//   010 MUL : unsigned shift-add, N iterations; r=product[N-1:0];
//             cout=|product[2N-1:N]; V=0
//   011 DIVU: restoring division, N iterations; r=quotient; cout=0; V=0
//   100 MOV : r=b; cout=0; V=0
//   101 REMU: as DIVU; r=remainder
//   110,111 : r=0, all flags 0, 1-cycle latency, done_o still pulses
// Divide by zero (DIVU/REMU with b==0): still N iterations.
//   DIVU r = all ones; REMU r = a; V=1; cout=0.
// zero_o / negative_o are derived from the final r for every opcode.
// Outputs update only at the edge entering DONE; stable otherwise, incl. through ITER.
// Reset asserted mid-operation aborts immediately: all outputs to reset values,
// no done_o pulse, IDLE on release.
// Iteration counter: ceil(log2 N)-bit; wraps only via reset or return to IDLE.
// TESTING (N=4 unless stated)
// 1. ADD 7+1 -> done cycle 1: r=8, cout=0, V=1, N=1, Z=0. ADD F+1 -> r=0, cout=1, Z=1, V=0.
// 2. SUB 0-1 -> r=F, cout=1, V=0. SUB 8-1 -> r=7, V=1. MOV b=A -> r=A, flags 0 except N=1.
// 3. MUL 5*3 -> done cycle 5: r=F, cout=0. MUL 6*3 -> r=2, cout=1.
//    Pulse start_i in cycles 1-4: ignored, ready_o=0.
// 4. DIVU 13/4 -> r=3 at cycle 5. REMU 13/4 -> r=1. DIVU 9/0 -> r=F, V=1. REMU 9/0 -> r=9, V=1.
// 5. Assert rst_i at cycle 2 of a MUL -> outputs 0, ready_o=1, no done_o.
//    Next ADD 2+2 -> r=4 normally.
// 6. N=8 random regression: 1000 ops vs reference model.
//    Check latency 1 / 9, held outputs between dones, opcodes 110/111 -> r=0.

Source files
------------

// File: rtl/alu_arith_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_arith_seq
// Purpose  : Multi-cycle arithmetic ALU: add/sub/mov in one cycle, iterative
//            unsigned multiply/divide/remainder, registered results and flags.
// Revision : 1.0
// ============================================================================
module alu_arith_seq #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [2:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         cout_o,
    output logic         overflow_o,
    output logic         zero_o,
    output logic         negative_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_mul  = 3'b010;
    localparam logic [2:0] c_op_divu = 3'b011;
    localparam logic [2:0] c_op_mov  = 3'b100;
    localparam logic [2:0] c_op_remu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic           r_cout;
    logic           r_ovf;
    logic           r_zero;
    logic           r_neg;

    logic           w_accept;
    logic           w_iter_op;
    logic           w_last;
    logic           w_load;
    logic [N:0]     w_add;
    logic [N:0]     w_sub;
    logic [N:0]     w_mul_sum;
    logic [N-1:0]   w_mul_hi;
    logic [N-1:0]   w_mul_lo;
    logic [N:0]     w_div_shift;
    logic [N+1:0]   w_div_diff;
    logic [N-1:0]   w_div_rem;
    logic [N-1:0]   w_div_q;
    logic [N-1:0]   w_res_1c;
    logic           w_cout_1c;
    logic           w_ovf_1c;
    logic [N-1:0]   w_res_it;
    logic           w_cout_it;
    logic           w_ovf_it;
    logic [N-1:0]   w_res;
    logic           w_cout;
    logic           w_ovf;

    assign w_accept  = start_i && (r_state == S_IDLE);
    assign w_iter_op = (opcode_i == c_op_mul) || (opcode_i == c_op_divu) ||
                       (opcode_i == c_op_remu);
    assign w_last    = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_iter_op ? S_ITER : S_DONE;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_add = {1'b0, a_i} + {1'b0, b_i};
    assign w_sub = {1'b0, a_i} - {1'b0, b_i};

    // Shift-add: r_hi accumulates, r_lo starts as the multiplier and fills with product bits.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(N+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[N:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[N-1:1]};

    // Restoring division: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_div_shift = {r_hi, r_lo[N-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_rem   = w_div_diff[N+1] ? w_div_shift[N-1:0] : w_div_diff[N-1:0];
    assign w_div_q     = {r_lo[N-2:0], ~w_div_diff[N+1]};

    always_comb begin
        w_res_1c  = '0;
        w_cout_1c = 1'b0;
        w_ovf_1c  = 1'b0;
        case (opcode_i)
            c_op_add: begin
                w_res_1c  = w_add[N-1:0];
                w_cout_1c = w_add[N];
                w_ovf_1c  = ~(a_i[N-1] ^ b_i[N-1]) & (w_add[N-1] ^ a_i[N-1]);
            end
            c_op_sub: begin
                w_res_1c  = w_sub[N-1:0];
                w_cout_1c = w_sub[N];
                w_ovf_1c  = (a_i[N-1] ^ b_i[N-1]) & (w_sub[N-1] ^ a_i[N-1]);
            end
            c_op_mov: w_res_1c = b_i;
            default: ;
        endcase
    end

    always_comb begin
        w_res_it  = '0;
        w_cout_it = 1'b0;
        w_ovf_it  = 1'b0;
        case (r_op)
            c_op_mul: begin
                w_res_it  = w_mul_lo;
                w_cout_it = |w_mul_hi;
            end
            c_op_divu: begin
                w_res_it = (r_b == '0) ? {N{1'b1}} : w_div_q;
                w_ovf_it = (r_b == '0);
            end
            c_op_remu: begin
                w_res_it = (r_b == '0) ? r_a : w_div_rem;
                w_ovf_it = (r_b == '0);
            end
            default: ;
        endcase
    end

    assign w_load = (w_accept && !w_iter_op) || ((r_state == S_ITER) && w_last);
    assign w_res  = (r_state == S_ITER) ? w_res_it  : w_res_1c;
    assign w_cout = (r_state == S_ITER) ? w_cout_it : w_cout_1c;
    assign w_ovf  = (r_state == S_ITER) ? w_ovf_it  : w_ovf_1c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= opcode_i;
            r_a   <= a_i;
            r_b   <= b_i;
            r_hi  <= '0;
            r_lo  <= (opcode_i == c_op_mul) ? b_i : a_i;
            r_cnt <= '0;
        end else if (r_state == S_ITER) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (r_op == c_op_mul) begin
                r_hi <= w_mul_hi;
                r_lo <= w_mul_lo;
            end else begin
                r_hi <= w_div_rem;
                r_lo <= w_div_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res;
            r_cout   <= w_cout;
            r_ovf    <= w_ovf;
            r_zero   <= (w_res == '0);
            r_neg    <= w_res[N-1];
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign result_o   = r_result;
    assign cout_o     = r_cout;
    assign overflow_o = r_ovf;
    assign zero_o     = r_zero;
    assign negative_o = r_neg;
endmodule
`default_nettype wire

// File: tb/tb_alu_arith_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_arith_seq
// Purpose  : Directed scoreboard bench for alu_arith_seq (N=4).
// Revision : 1.0
// ============================================================================
module tb_alu_arith_seq;
    localparam int N = 4;
    localparam int LAT_1 = 1;
    localparam int LAT_IT = N + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   opcode = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    wire          ready;
    wire          done;
    wire  [N-1:0] result;
    wire          cout;
    wire          ovf;
    wire          zero;
    wire          neg;

    typedef struct {
        logic [N-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    int           ndone = 0;
    int           nissued = 0;
    logic         mon_en = 1'b0;
    logic [N+3:0] held = '0;

    alu_arith_seq #(.N(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .opcode_i   (opcode),
        .a_i        (a),
        .b_i        (b),
        .ready_o    (ready),
        .done_o     (done),
        .result_o   (result),
        .cout_o     (cout),
        .overflow_o (ovf),
        .zero_o     (zero),
        .negative_o (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expectation; between pulses outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
        end else if (done) begin
            ndone++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_e = q.pop_front();
                chk("result", {28'd0, result}, {28'd0, m_e.res});
                chk("cout", {31'd0, cout}, {31'd0, m_e.c});
                chk("overflow", {31'd0, ovf}, {31'd0, m_e.v});
                chk("zero", {31'd0, zero}, {31'd0, m_e.z});
                chk("negative", {31'd0, neg}, {31'd0, m_e.n});
                chk("latency_cycle", cyc, m_e.cyc);
            end
            held = {result, cout, ovf, zero, neg};
        end else if (mon_en) begin
            chk("held_outputs", {24'd0, result, cout, ovf, zero, neg}, {24'd0, held});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input int lat, input logic [N-1:0] er, input logic ec, input logic ev,
                         input logic poke);
        exp_t e;
        int   k;
        @(negedge clk);
        chk("ready_idle", {31'd0, ready}, 32'd1);
        start  = 1'b1;
        opcode = op;
        a      = ta;
        b      = tb_v;
        e.res  = er;
        e.c    = ec;
        e.v    = ev;
        e.z    = (er == '0);
        e.n    = er[N-1];
        e.cyc  = cyc + lat;
        q.push_back(e);
        nissued++;
        @(negedge clk);
        start  = 1'b0;
        opcode = 3'($urandom);
        a      = N'($urandom);
        b      = N'($urandom);
        if (poke) begin
            for (int i = 0; i < N; i++) begin
                start = 1'b1;
                chk("ready_busy", {31'd0, ready}, 32'd0);
                @(negedge clk);
            end
            start = 1'b0;
        end
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_outputs", {24'd0, result, cout, ovf, zero, neg}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        //    op      a      b      lat     res    c     v     poke
        issue(3'b000, 4'h7, 4'h1, LAT_1,  4'h8, 1'b0, 1'b1, 1'b0);
        issue(3'b000, 4'hF, 4'h1, LAT_1,  4'h0, 1'b1, 1'b0, 1'b0);
        issue(3'b000, 4'h3, 4'h4, LAT_1,  4'h7, 1'b0, 1'b0, 1'b0);
        issue(3'b001, 4'h0, 4'h1, LAT_1,  4'hF, 1'b1, 1'b0, 1'b0);
        issue(3'b001, 4'h8, 4'h1, LAT_1,  4'h7, 1'b0, 1'b1, 1'b0);
        issue(3'b001, 4'h5, 4'h5, LAT_1,  4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'b100, 4'h3, 4'hA, LAT_1,  4'hA, 1'b0, 1'b0, 1'b0);
        issue(3'b010, 4'h5, 4'h3, LAT_IT, 4'hF, 1'b0, 1'b0, 1'b1);
        issue(3'b010, 4'h6, 4'h3, LAT_IT, 4'h2, 1'b1, 1'b0, 1'b0);
        issue(3'b011, 4'hD, 4'h4, LAT_IT, 4'h3, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 4'hD, 4'h4, LAT_IT, 4'h1, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 4'h9, 4'h0, LAT_IT, 4'hF, 1'b0, 1'b1, 1'b0);
        issue(3'b101, 4'h9, 4'h0, LAT_IT, 4'h9, 1'b0, 1'b1, 1'b0);
        issue(3'b011, 4'hF, 4'h1, LAT_IT, 4'hF, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 4'h7, 4'h9, LAT_IT, 4'h7, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 4'h2, 4'h3, LAT_IT, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'b110, 4'h5, 4'h3, LAT_1,  4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'b111, 4'hF, 4'hF, LAT_1,  4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'b010, 4'hF, 4'hF, LAT_IT, 4'h1, 1'b1, 1'b0, 1'b0);

        // Abort a multiply in flight; no done pulse may follow.
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'b010;
        a      = 4'h5;
        b      = 4'h3;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_outputs", {24'd0, result, cout, ovf, zero, neg}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        issue(3'b000, 4'h2, 4'h2, LAT_1,  4'h4, 1'b0, 1'b0, 1'b0);

        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", q.size(), 32'd0);
        chk("done_count", ndone, nissued);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
